fft_out_reorder: RTL

- Output-side reorder buffer for the streaming FFT datapath; the read-side counterpart of the permuting input data FIFO.
- Accepts one natural-order frame of PROBLEM_SIZE words, marked by a ctrl_in pulse on word 0.
- Emits each frame in bit-reversed index order, marked by a ctrl_out pulse on the first output word.
- Ping-pong dual-bank storage, so back-to-back frames stream with no bubbles.

---
 rtl/fft_out_reorder_pkg.sv | 34 +++
 rtl/fft_out_reorder_if.sv | 27 ++
 rtl/fft_out_reorder_dp_blk_ram.sv | 22 ++
 rtl/fft_out_reorder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fft_out_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// Holds the write/read FSM state encodings and the generic bit-reversal function.
package fft_out_reorder_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    // Widest bank address that bitrev supports.
    localparam int BR_MAX_W = 16;
    localparam int BR_IDX_W = $clog2(BR_MAX_W);

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DRAIN
    } rd_state_t;

    // Reverses the low w bits of v. Constant w reduces this to wiring.
    function automatic logic [BR_MAX_W-1:0] bitrev(input logic [BR_MAX_W-1:0] v,
                                                   input int unsigned w);
        logic [BR_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BR_MAX_W; i++) begin
            if (i < w) begin
                r[BR_IDX_W'(i)] = v[BR_IDX_W'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Stream bundle for the reorder buffer: natural-order input side and
// bit-reversed output side.
interface fft_out_reorder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ctrl_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ctrl_out;

    modport slave (
        input  data_in,
        input  ctrl_in,
        output data_out,
        output valid_out,
        output ctrl_out
    );

    modport master (
        output data_in,
        output ctrl_in,
        input  data_out,
        input  valid_out,
        input  ctrl_out
    );
endinterface

// File: rtl/fft_out_reorder_dp_blk_ram.sv
// Simple dual-port block RAM: one write port, one synchronous read port
// with a single cycle of latency. Storage is never reset.
module dp_blk_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: frames are written in natural order into one bank
// while the other bank is drained in bit-reversed index order.
module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = 4,
    parameter int PROBLEM_SIZE = 16
) (
    input  logic               clk,
    input  logic               rst,
    fft_out_reorder_if.slave   bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(PROBLEM_SIZE - 1);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ctrl;

    wr_state_t             wr_state, wr_state_n;
    logic [ADDR_WIDTH-1:0] wr_cnt, wr_cnt_n;
    logic                  wr_bank, wr_bank_n;
    logic                  full_bank, full_bank_n;
    logic                  handoff, handoff_n;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;

    rd_state_t             rd_state, rd_state_n;
    logic [ADDR_WIDTH-1:0] rd_cnt, rd_cnt_n;
    logic                  rd_bank, rd_bank_n;
    logic                  rd_en;
    logic                  rd_first;
    logic [ADDR_WIDTH-1:0] rd_rev;

    logic [DATA_WIDTH-1:0] ram_q;
    logic                  en_d;
    logic                  first_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_data <= '0;
            in_ctrl <= 1'b0;
        end else begin
            in_data <= bus.data_in;
            in_ctrl <= bus.ctrl_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state  <= W_IDLE;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            full_bank <= 1'b0;
            handoff   <= 1'b0;
        end else begin
            wr_state  <= wr_state_n;
            wr_cnt    <= wr_cnt_n;
            wr_bank   <= wr_bank_n;
            full_bank <= full_bank_n;
            handoff   <= handoff_n;
        end
    end

    // A registered ctrl in either state restarts at address 0 of the current
    // bank, so an abort and a normal frame start share one path.
    always_comb begin
        wr_state_n  = wr_state;
        wr_cnt_n    = wr_cnt;
        wr_bank_n   = wr_bank;
        full_bank_n = full_bank;
        handoff_n   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = wr_cnt;
        if (in_ctrl) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_cnt_n   = ADDR_WIDTH'(1);
            wr_state_n = W_FILL;
        end else if (wr_state == W_FILL) begin
            wr_en    = 1'b1;
            wr_cnt_n = wr_cnt + ADDR_WIDTH'(1);
            if (wr_cnt == LAST) begin
                wr_bank_n   = ~wr_bank;
                full_bank_n = wr_bank;
                handoff_n   = 1'b1;
                wr_state_n  = W_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
            rd_bank  <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            rd_cnt   <= rd_cnt_n;
            rd_bank  <= rd_bank_n;
        end
    end

    // The drain bank is latched on acceptance: in back-to-back streaming the
    // next handoff lands while the last word of the current frame is read.
    always_comb begin
        rd_state_n = rd_state;
        rd_cnt_n   = rd_cnt;
        rd_bank_n  = rd_bank;
        rd_en      = 1'b0;
        rd_first   = 1'b0;
        unique case (rd_state)
            R_IDLE: begin
                if (handoff) begin
                    rd_state_n = R_DRAIN;
                    rd_cnt_n   = '0;
                    rd_bank_n  = full_bank;
                end
            end
            R_DRAIN: begin
                rd_en    = 1'b1;
                rd_first = (rd_cnt == '0);
                rd_cnt_n = rd_cnt + ADDR_WIDTH'(1);
                if (rd_cnt == LAST) begin
                    if (handoff) begin
                        rd_bank_n = full_bank;
                    end else begin
                        rd_state_n = R_IDLE;
                    end
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    assign rd_rev = ADDR_WIDTH'(bitrev(BR_MAX_W'(rd_cnt), ADDR_WIDTH));

    dp_blk_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, wr_addr}),
        .wr_data (in_data),
        .rd_addr ({rd_bank, rd_rev}),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_d          <= 1'b0;
            first_d       <= 1'b0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.ctrl_out  <= 1'b0;
        end else begin
            en_d          <= rd_en;
            first_d       <= rd_first;
            bus.valid_out <= en_d;
            bus.ctrl_out  <= first_d;
            if (en_d) begin
                bus.data_out <= ram_q;
            end
        end
    end
endmodule
